// File: rtl/keccak_clkgate_ctrl.sv
// rtl/keccak_clkgate_ctrl.sv - clock-gate enable sequencer for the keccak permutation core
//
// Sequences the keccak core clock gate around permutation requests:
// wakes the gated clock for WAKE_CYCLES before forwarding start, keeps it
// running until done, then lingers IDLE_CYCLES idle cycles before gating.
//
// Ports:
//   clk_i          free-running clock
//   rst_i          synchronous active-high reset
//   start_i        permutation request pulse from the register interface
//   done_i         completion pulse from the keccak core
//   busy_i         keccak core activity flag (stretches the idle hysteresis)
//   cfg_force_on_i static bit that keeps the gated clock enabled
//   clk_en_o       enable into the keccak clock gate
//   start_o        single-cycle start pulse to the core
//   done_o         single-cycle completion pulse to the register interface
//   busy_o         high from start acceptance until done
//   err_o          sticky protocol-error flag
module keccak_clkgate_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic done_i,
  input  logic busy_i,
  input  logic cfg_force_on_i,
  output logic clk_en_o,
  output logic start_o,
  output logic done_o,
  output logic busy_o,
  output logic err_o
);

  localparam int MAX_CYCLES = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Enable is decoded from the state flop only; rst_i is ORed in so the
  // gated domain sees edges while it is being reset.
  assign clk_en_o = (state != OFF) | cfg_force_on_i | rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= OFF;
      cnt     <= '0;
      start_o <= 1'b0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      start_o <= 1'b0;
      done_o  <= 1'b0;
      case (state)
        OFF: begin
          if (done_i) err_o <= 1'b1;
          if (start_i) begin
            state  <= WAKE;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        WAKE: begin
          if (start_i || done_i) err_o <= 1'b1;
          if (cnt == WAKE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            start_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          // A start arriving with done is dropped; done wins.
          if (start_i) err_o <= 1'b1;
          if (done_i) begin
            state  <= HOLD;
            cnt    <= '0;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        HOLD: begin
          if (done_i) err_o <= 1'b1;
          // Clock is still running, so a new request skips the wake phase
          // and beats any idle expiry in the same cycle.
          if (start_i) begin
            state   <= RUN;
            cnt     <= '0;
            start_o <= 1'b1;
            busy_o  <= 1'b1;
          end else if (busy_i) begin
            cnt <= '0;
          end else if (cnt == IDLE_LAST) begin
            state <= OFF;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
